// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART receiver definitions
// Purpose: FSM state codes and the default oversample ratio shared by the
//          UART receiver, transmitter and baud-rate setup.
// Ports:   none (package)
package uart_rx_pkg;

  // Default number of oversample ticks per bit period.
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// rtl/uart_rx_sync_2ff.sv - two-flop synchroniser with configurable reset value
// Purpose: brings an asynchronous signal into the P_CLK domain.
// Ports:   P_CLK  in  system clock
//          reset  in  asynchronous, active-high reset
//          d_i    in  WIDTH  asynchronous input
//          q_o    out WIDTH  synchronised output
module uart_rx_sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             P_CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge P_CLK or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver
// Purpose: synchronises the serial line, detects the start bit, samples each
//          bit at mid-period and delivers the word with valid/error pulses.
// Ports:   P_CLK         in   system clock
//          reset         in   asynchronous, active-high reset
//          i_RX          in   serial line, idles high
//          i_TICK        in   oversample strobe, OVERSAMPLE per bit period
//          o_BAUD_EN     out  baud generator enable, high when not in reset
//          o_DATA        out  DATA_BITS  last received word
//          o_VALID       out  1-cycle pulse, o_DATA updated
//          o_PARITY_ERR  out  1-cycle pulse with o_VALID on parity mismatch
//          o_FRAME_ERR   out  1-cycle pulse, stop bit sampled low
//          o_BUSY        out  high from start detect until back in IDLE
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 P_CLK,
  input  logic                 reset,
  input  logic                 i_RX,
  input  logic                 i_TICK,
  output logic                 o_BAUD_EN,
  output logic [DATA_BITS-1:0] o_DATA,
  output logic                 o_VALID,
  output logic                 o_PARITY_ERR,
  output logic                 o_FRAME_ERR,
  output logic                 o_BUSY
);

  localparam int          TW      = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]  B_LAST  = 4'(DATA_BITS - 1);
  localparam logic        ODD_BIT = (PARITY_ODD != 0);

  logic                 rx_s;
  uart_state_e          state_q;
  logic [TW-1:0]        tcnt_q;
  logic [3:0]           bcnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q;

  uart_rx_sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .P_CLK (P_CLK),
    .reset (reset),
    .d_i   (i_RX),
    .q_o   (rx_s)
  );

  assign o_BAUD_EN = ~reset;

  always_ff @(posedge P_CLK or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tcnt_q       <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      o_DATA       <= '0;
      o_VALID      <= 1'b0;
      o_PARITY_ERR <= 1'b0;
      o_FRAME_ERR  <= 1'b0;
      o_BUSY       <= 1'b0;
    end else begin
      o_VALID      <= 1'b0;
      o_PARITY_ERR <= 1'b0;
      o_FRAME_ERR  <= 1'b0;
      if (i_TICK) begin
        tcnt_q <= tcnt_q + TW'(1);
      end

      case (state_q)
        ST_IDLE: begin
          tcnt_q <= '0;
          if (!rx_s) begin
            // Start edge is not tick-driven, so a coincident tick already
            // counts toward the start-bit half period.
            state_q <= ST_START;
            tcnt_q  <= TW'(i_TICK);
            bcnt_q  <= '0;
            perr_q  <= 1'b0;
            o_BUSY  <= 1'b1;
          end
        end

        ST_START: begin
          if (i_TICK && tcnt_q == T_HALF) begin
            tcnt_q <= '0;
            if (!rx_s) begin
              state_q <= ST_DATA;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state_q <= ST_IDLE;
              o_BUSY  <= 1'b0;
            end
          end
        end

        ST_DATA: begin
          // tcnt wraps from T_LAST to 0 by itself, keeping mid-bit alignment.
          if (i_TICK && tcnt_q == T_LAST) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (bcnt_q == B_LAST) begin
              bcnt_q  <= '0;
              state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bcnt_q <= bcnt_q + 4'd1;
            end
          end
        end

        ST_PARITY: begin
          if (i_TICK && tcnt_q == T_LAST) begin
            perr_q  <= rx_s ^ (^shift_q) ^ ODD_BIT;
            state_q <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (i_TICK && tcnt_q == T_LAST) begin
            if (rx_s) begin
              o_DATA       <= shift_q;
              o_VALID      <= 1'b1;
              o_PARITY_ERR <= perr_q;
              o_BUSY       <= 1'b0;
              state_q      <= ST_IDLE;
            end else begin
              o_FRAME_ERR <= 1'b1;
              state_q     <= ST_BREAK;
            end
          end
        end

        ST_BREAK: begin
          // Stay busy while the line is held low (break or stuck line).
          if (rx_s) begin
            tcnt_q  <= '0;
            o_BUSY  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          tcnt_q  <= '0;
          o_BUSY  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
